// File: rtl/ds_arb_pkg.sv
// Phase encodings and status-word constants shared by the RAM arbiter
// and the control FSM's status decode.
package ds_arb_pkg;

  typedef enum logic [1:0] {
    PH_LOAD = 2'b00,
    PH_RUN  = 2'b01,
    PH_DONE = 2'b10
  } phase_e;

  localparam logic [1:0] STATUS_LOAD = 2'b00;
  localparam logic [1:0] STATUS_RUN  = 2'b01;
  localparam logic [1:0] STATUS_DONE = 2'b10;

  function automatic logic [1:0] phase_to_status(input phase_e ph);
    case (ph)
      PH_RUN:  return STATUS_RUN;
      PH_DONE: return STATUS_DONE;
      default: return STATUS_LOAD;
    endcase
  endfunction

endpackage

// File: rtl/mem_phase_arbiter_if.sv
// Single-beat RAM access port (req/gnt with registered read return);
// one instance each for the host loader and the core.
interface mem_phase_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/arb_rd_pipe.sv
// Tracks outstanding reads: a valid/owner-tag shift register that captures
// RAM data RD_LAT clocks after issue and routes rvalid/rdata back to the issuer.
module arb_rd_pipe #(
  parameter int RD_LAT = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_issue,
  input  logic              i_tag_core,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_host_rvalid,
  output logic              o_core_rvalid,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic [DATA_W-1:0] o_core_rdata
);

  logic [RD_LAT:0]   r_vld;
  logic [RD_LAT:0]   r_tag;
  logic              r_host_rvalid;
  logic              r_core_rvalid;
  logic [DATA_W-1:0] r_host_rdata;
  logic [DATA_W-1:0] r_core_rdata;
  logic              w_land_host;
  logic              w_land_core;

  // Last stage is the cycle in which the RAM presents the read data.
  assign w_land_host = r_vld[RD_LAT] & ~r_tag[RD_LAT];
  assign w_land_core = r_vld[RD_LAT] &  r_tag[RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld         <= '0;
      r_tag         <= '0;
      r_host_rvalid <= 1'b0;
      r_core_rvalid <= 1'b0;
      r_host_rdata  <= '0;
      r_core_rdata  <= '0;
    end else begin
      r_vld         <= {r_vld[RD_LAT-1:0], i_issue};
      r_tag         <= {r_tag[RD_LAT-1:0], i_tag_core};
      r_host_rvalid <= w_land_host;
      r_core_rvalid <= w_land_core;
      if (w_land_host) r_host_rdata <= i_mem_rdata;
      if (w_land_core) r_core_rdata <= i_mem_rdata;
    end
  end

  assign o_busy        = (|r_vld) | r_host_rvalid | r_core_rvalid;
  assign o_host_rvalid = r_host_rvalid;
  assign o_core_rvalid = r_core_rvalid;
  assign o_host_rdata  = r_host_rdata;
  assign o_core_rdata  = r_core_rdata;

endmodule

// File: rtl/mem_phase_arbiter.sv
// Time-shares the single RAM port between host loader and core, and sequences LOAD/RUN/DONE.
//   state   | meaning
//   PH_LOAD | host owns RAM, waiting for host_start
//   PH_RUN  | core owns RAM, run_cycles counting, waiting for core_end
//   PH_DONE | host owns RAM, results readable, host_start reruns / host_clear reloads
module mem_phase_arbiter
  import ds_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_host_start,
  input  logic                i_host_clear,
  input  logic                i_core_end,
  mem_phase_arbiter_if.slave  host,
  mem_phase_arbiter_if.slave  core,
  output logic                o_host_stall,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic [1:0]          o_status,
  output logic [CNT_W-1:0]    o_run_cycles
);

  phase_e            r_phase, w_phase_nxt;
  phase_e            r_pend_tgt, w_evt_tgt, w_tgt;
  logic              r_pend, w_evt, w_trans, w_take;
  logic              r_host_gnt, r_core_gnt;
  logic              r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [CNT_W-1:0]  r_run_cycles;
  logic              w_core_owns, w_busy, w_pipe_busy, w_grant;
  logic              w_own_req, w_own_we;
  logic [ADDR_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_wdata;
  logic              w_host_rvalid, w_core_rvalid;
  logic [DATA_W-1:0] w_host_rdata, w_core_rdata;

  always_comb begin
    w_evt     = 1'b0;
    w_evt_tgt = r_phase;
    case (r_phase)
      PH_LOAD: if (i_host_start) begin w_evt = 1'b1; w_evt_tgt = PH_RUN; end
      PH_DONE: begin
        if (i_host_start)      begin w_evt = 1'b1; w_evt_tgt = PH_RUN;  end
        else if (i_host_clear) begin w_evt = 1'b1; w_evt_tgt = PH_LOAD; end
      end
      PH_RUN:  if (i_core_end) begin w_evt = 1'b1; w_evt_tgt = PH_DONE; end
      default: ;
    endcase
  end

  // A latched transition takes precedence over any newer request.
  assign w_trans = r_pend | w_evt;
  assign w_tgt   = r_pend ? r_pend_tgt : w_evt_tgt;
  assign w_busy  = r_host_gnt | r_core_gnt | w_pipe_busy;
  assign w_take  = w_trans & ~w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_phase <= PH_LOAD;
    else        r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = r_phase;
    if (w_take) w_phase_nxt = w_tgt;
  end

  always_comb begin
    o_status     = phase_to_status(r_phase);
    w_core_owns  = (r_phase == PH_RUN);
    o_host_stall = host.req & w_core_owns;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= 1'b0;
      r_pend_tgt <= PH_LOAD;
    end else if (w_take) begin
      r_pend     <= 1'b0;
    end else if (w_evt && !r_pend) begin
      r_pend     <= 1'b1;
      r_pend_tgt <= w_evt_tgt;
    end
  end

  assign w_own_req   = w_core_owns ? core.req   : host.req;
  assign w_own_we    = w_core_owns ? core.we    : host.we;
  assign w_own_addr  = w_core_owns ? core.addr  : host.addr;
  assign w_own_wdata = w_core_owns ? core.wdata : host.wdata;
  assign w_grant     = w_own_req & ~w_busy & ~w_trans;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_host_gnt  <= 1'b0;
      r_core_gnt  <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_host_gnt  <= w_grant & ~w_core_owns;
      r_core_gnt  <= w_grant &  w_core_owns;
      r_mem_en    <= w_grant;
      r_mem_we    <= w_grant & w_own_we;
      r_mem_addr  <= w_grant ? w_own_addr  : '0;
      r_mem_wdata <= w_grant ? w_own_wdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_cycles <= '0;
    end else if (w_take && w_tgt == PH_RUN) begin
      r_run_cycles <= '0;
    end else if (r_phase == PH_RUN && !(&r_run_cycles)) begin
      r_run_cycles <= r_run_cycles + CNT_W'(1);
    end
  end

  arb_rd_pipe #(.RD_LAT(RD_LAT), .DATA_W(DATA_W)) u_rd_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_issue       (w_grant & ~w_own_we),
    .i_tag_core    (w_core_owns),
    .i_mem_rdata   (i_mem_rdata),
    .o_busy        (w_pipe_busy),
    .o_host_rvalid (w_host_rvalid),
    .o_core_rvalid (w_core_rvalid),
    .o_host_rdata  (w_host_rdata),
    .o_core_rdata  (w_core_rdata)
  );

  assign host.gnt     = r_host_gnt;
  assign host.rvalid  = w_host_rvalid;
  assign host.rdata   = w_host_rdata;
  assign core.gnt     = r_core_gnt;
  assign core.rvalid  = w_core_rvalid;
  assign core.rdata   = w_core_rdata;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_run_cycles = r_run_cycles;

endmodule

// File: tb/tb_mem_phase_arbiter.sv
// Directed bench for mem_phase_arbiter with a 2-clock-latency RAM model.
module tb_mem_phase_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_start, host_clear, core_end;
  logic        host_stall, mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [1:0]  status;
  logic [31:0] run_cycles;
  int          n_chk = 0;
  int          n_err = 0;

  mem_phase_arbiter_if #(.ADDR_W(16), .DATA_W(8)) host_if ();
  mem_phase_arbiter_if #(.ADDR_W(16), .DATA_W(8)) core_if ();

  mem_phase_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(2), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_host_start (host_start),
    .i_host_clear (host_clear),
    .i_core_end   (core_end),
    .host         (host_if),
    .core         (core_if),
    .o_host_stall (host_stall),
    .o_mem_en     (mem_en),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_status     (status),
    .o_run_cycles (run_cycles)
  );

  always #5 clk = ~clk;

  // RAM model: data presented only in the cycle RD_LAT clocks after mem_en.
  logic [7:0] ram [0:255];
  logic       rv1, rv2;
  logic [7:0] rd1, rd2;
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    rv1 <= mem_en && !mem_we;
    rd1 <= ram[mem_addr[7:0]];
    rv2 <= rv1;
    rd2 <= rd1;
  end
  assign mem_rdata = (rv2 === 1'b1) ? rd2 : 8'h00;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_drive(input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
    host_if.req = req; host_if.we = we; host_if.addr = a; host_if.wdata = d;
  endtask

  task automatic core_drive(input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
    core_if.req = req; core_if.we = we; core_if.addr = a; core_if.wdata = d;
  endtask

  initial begin
    rst_n = 1'b0; host_start = 1'b0; host_clear = 1'b0; core_end = 1'b0;
    host_drive(1'b0, 1'b0, 16'h0, 8'h0);
    core_drive(1'b0, 1'b0, 16'h0, 8'h0);
    tick(2);
    chk("rst_status", status, 2'b00);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_host_gnt", host_if.gnt, 0);
    chk("rst_host_rdata", host_if.rdata, 0);
    rst_n = 1'b1;
    tick();

    // LOAD: host write 0xA5 -> 0x0010
    host_drive(1'b1, 1'b1, 16'h0010, 8'hA5);
    tick();
    chk("wr_gnt", host_if.gnt, 1);
    chk("wr_core_gnt", core_if.gnt, 0);
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 16'h0010);
    chk("wr_mem_wdata", mem_wdata, 8'hA5);
    host_drive(1'b0, 1'b0, 16'h0, 8'h0);
    tick();
    chk("wr_gnt_drop", host_if.gnt, 0);
    chk("wr_mem_en_drop", mem_en, 0);

    // LOAD: read back, req held to probe busy window (R)
    host_drive(1'b1, 1'b0, 16'h0010, 8'h0);
    tick();                                   // R+1
    chk("rd_gnt", host_if.gnt, 1);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    tick();                                   // R+2
    chk("rd_rvalid_r2", host_if.rvalid, 0);
    chk("rd_gnt_r2", host_if.gnt, 0);
    tick();                                   // R+3
    chk("rd_rvalid_r3", host_if.rvalid, 0);
    chk("rd_gnt_r3", host_if.gnt, 0);
    tick();                                   // R+4
    chk("rd_rvalid_r4", host_if.rvalid, 1);
    chk("rd_rdata_r4", host_if.rdata, 8'hA5);
    chk("rd_gnt_r4", host_if.gnt, 0);
    tick();                                   // R+5
    chk("rd_rvalid_r5", host_if.rvalid, 0);
    chk("rd_gnt_r5", host_if.gnt, 0);
    tick();                                   // R+6
    chk("rd2_gnt_r6", host_if.gnt, 1);
    host_drive(1'b0, 1'b0, 16'h0, 8'h0);
    tick(3);                                  // R+9
    chk("rd2_rvalid", host_if.rvalid, 1);
    chk("rd2_rdata", host_if.rdata, 8'hA5);
    tick();

    // Back-to-back writes: req held through the gnt cycle (A)
    host_drive(1'b1, 1'b1, 16'h0020, 8'h3C);
    tick();
    chk("b2b_gnt_a1", host_if.gnt, 1);
    tick();
    chk("b2b_gnt_a2", host_if.gnt, 0);
    tick();
    chk("b2b_gnt_a3", host_if.gnt, 1);
    host_drive(1'b0, 1'b0, 16'h0, 8'h0);
    tick();
    chk("b2b_gnt_a4", host_if.gnt, 0);

    // Ownership: core_req in LOAD is never granted
    core_drive(1'b1, 1'b0, 16'h0005, 8'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("own_core_gnt", core_if.gnt, 0);
      chk("own_mem_en", mem_en, 0);
    end
    core_drive(1'b0, 1'b0, 16'h0, 8'h0);
    tick();

    // Phase sequencing (S)
    host_start = 1'b1;
    tick();                                   // S+1
    host_start = 1'b0;
    chk("seq_status_run", status, 2'b01);
    chk("seq_rc_start", run_cycles, 0);
    host_drive(1'b1, 1'b1, 16'h0030, 8'h77);
    tick();                                   // S+2
    chk("seq_host_stall", host_stall, 1);
    chk("seq_host_gnt", host_if.gnt, 0);
    chk("seq_mem_en", mem_en, 0);
    tick();                                   // S+3
    chk("seq_host_gnt2", host_if.gnt, 0);
    chk("seq_rc_s3", run_cycles, 2);
    host_drive(1'b0, 1'b0, 16'h0, 8'h0);
    tick(97);                                 // S+100
    core_end = 1'b1;
    tick();                                   // S+101
    core_end = 1'b0;
    chk("seq_status_done", status, 2'b10);
    chk("seq_rc_100", run_cycles, 100);
    tick();
    chk("seq_rc_frozen", run_cycles, 100);

    // DONE: start + clear together -> RUN (D)
    host_start = 1'b1; host_clear = 1'b1;
    tick();                                   // D+1
    host_start = 1'b0; host_clear = 1'b0;
    chk("pri_status_run", status, 2'b01);
    chk("pri_rc_restart", run_cycles, 0);
    tick();                                   // D+2 = C
    chk("pri_rc_one", run_cycles, 1);

    // Pending transition: core read granted with core_end in its gnt cycle
    core_drive(1'b1, 1'b0, 16'h0010, 8'h0);
    tick();                                   // C+1
    chk("pend_core_gnt", core_if.gnt, 1);
    chk("pend_host_gnt", host_if.gnt, 0);
    core_end = 1'b1;
    tick();                                   // C+2
    core_end = 1'b0;
    core_drive(1'b1, 1'b0, 16'h0020, 8'h0);
    chk("pend_status_c2", status, 2'b01);
    chk("pend_rvalid_c2", core_if.rvalid, 0);
    tick();                                   // C+3
    chk("pend_status_c3", status, 2'b01);
    tick();                                   // C+4
    chk("pend_core_rvalid", core_if.rvalid, 1);
    chk("pend_core_rdata", core_if.rdata, 8'hA5);
    chk("pend_host_rvalid", host_if.rvalid, 0);
    chk("pend_status_c4", status, 2'b01);
    tick();                                   // C+5
    chk("pend_status_c5", status, 2'b01);
    chk("pend_core_gnt_c5", core_if.gnt, 0);
    tick();                                   // C+6
    chk("pend_status_done", status, 2'b10);
    chk("pend_core_gnt_c6", core_if.gnt, 0);
    chk("pend_mem_en_c6", mem_en, 0);
    chk("pend_rc", run_cycles, 7);
    core_drive(1'b0, 1'b0, 16'h0, 8'h0);

    // DONE: host_clear alone -> LOAD
    host_clear = 1'b1;
    tick();
    host_clear = 1'b0;
    chk("clr_status_load", status, 2'b00);
    chk("clr_rc_frozen", run_cycles, 7);
    core_end = 1'b1;
    tick();
    core_end = 1'b0;
    tick();
    chk("load_core_end_ignored", status, 2'b00);

    // Reset in the middle of a host read (M)
    host_drive(1'b1, 1'b0, 16'h0010, 8'h0);
    tick();                                   // M+1
    chk("mrst_gnt", host_if.gnt, 1);
    host_drive(1'b0, 1'b0, 16'h0, 8'h0);
    tick();                                   // M+2
    rst_n = 1'b0;
    tick();
    chk("mrst_status", status, 2'b00);
    chk("mrst_rc", run_cycles, 0);
    chk("mrst_rvalid", host_if.rvalid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mrst_no_rvalid", host_if.rvalid, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
